// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for 32 requesters with a programmable hold limit.
// Registered grant is output as an index and as a one-hot select word.
module rr_arbiter_32 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req,
  output logic        gnt_valid,
  output logic [4:0]  gnt_idx,
  output logic [31:0] gnt_onehot,
  output logic        gnt_preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [4:0]  last_idx;
  logic [7:0]  hold_cnt;

  logic [31:0] search_vec;
  logic [4:0]  cand;
  logic        win_found;
  logic [4:0]  win_idx;
  logic        holder_req;

  // While granted, last_idx is the holder, so masking it excludes the holder
  // from re-arbitration; offset 32 revisits last_idx itself, which matters in IDLE.
  always_comb begin
    holder_req = req[last_idx];
    search_vec = (state == GRANT) ? (req & ~(32'd1 << last_idx)) : req;
    cand       = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      cand = last_idx + 5'(i + 1);
      if (!win_found && search_vec[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_idx    <= '1;
      hold_cnt    <= '0;
      gnt_valid   <= 1'b0;
      gnt_idx     <= '0;
      gnt_onehot  <= '0;
      gnt_preempt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt    <= '0;
          gnt_preempt <= 1'b0;
          if (win_found) begin
            state      <= GRANT;
            last_idx   <= win_idx;
            gnt_valid  <= 1'b1;
            gnt_idx    <= win_idx;
            gnt_onehot <= 32'd1 << win_idx;
          end
        end
        GRANT: begin
          if (holder_req && (hold_cnt < HOLD_LAST)) begin
            hold_cnt    <= hold_cnt + 8'd1;
            gnt_preempt <= 1'b0;
          end else if (win_found) begin
            // Handoff at the same edge; a still-requesting holder means expiry.
            last_idx    <= win_idx;
            hold_cnt    <= '0;
            gnt_valid   <= 1'b1;
            gnt_idx     <= win_idx;
            gnt_onehot  <= 32'd1 << win_idx;
            gnt_preempt <= holder_req;
          end else if (holder_req) begin
            hold_cnt    <= '0;
            gnt_preempt <= 1'b0;
          end else begin
            state       <= IDLE;
            hold_cnt    <= '0;
            gnt_valid   <= 1'b0;
            gnt_idx     <= '0;
            gnt_onehot  <= '0;
            gnt_preempt <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
